// File: rtl/cpu_pkg.sv
// Shared CPU constants: address width, default reset vector and the PC step.
// The PC register and the datapath's fetch adder both use PC_STEP.
// No ports; import with cpu_pkg::*.
package cpu_pkg;

    localparam int          ADDR_W            = 32;
    localparam logic [31:0] RESET_VECTOR_DFLT = 32'h0000_0000;
    localparam int          PC_STEP           = 4;

endpackage : cpu_pkg

// File: rtl/pc_reg_if.sv
// Bus between the datapath and the program counter register.
// master: datapath side (drives PCin, observes PC state).
// slave : pc_reg side (takes PCin, drives PCout/PCplus4/misaligned/started).
interface pc_reg_if #(
    parameter int WIDTH = 32
);

    logic [WIDTH-1:0] PCin;
    logic [WIDTH-1:0] PCout;
    logic [WIDTH-1:0] PCplus4;
    logic             misaligned;
    logic             started;

    modport master (
        output PCin,
        input  PCout,
        input  PCplus4,
        input  misaligned,
        input  started
    );

    modport slave (
        input  PCin,
        output PCout,
        output PCplus4,
        output misaligned,
        output started
    );

endinterface : pc_reg_if

// File: rtl/pc_reg.sv
// Program counter register for the single-cycle MIPS CPU; loads PCin every rising edge.
// Latency: 1 cycle PCin->PCout; PCplus4 and misaligned are combinational from PCout.
// Backpressure: none; there is no enable or stall, the load is unconditional.
//
// Ports: clock, reset (async, active-high), pc_bus (pc_reg_if.slave:
//   PCin in; PCout, PCplus4, misaligned, started out).
// Optional macro PC_FORCE_ALIGN_EN: clears PCin[1:0] and RESET_VECTOR[1:0]
//   before use and ties misaligned low. Default build loads PCin verbatim.
module pc_reg
    import cpu_pkg::*;
#(
    parameter int          WIDTH        = ADDR_W,
    parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DFLT
) (
    input  logic     clock,
    input  logic     reset,
    pc_reg_if.slave  pc_bus
);

    // RESET_VECTOR is 32 bits wide; a size cast truncates or zero-extends it.
    localparam logic [WIDTH-1:0] RV_SIZED = WIDTH'(RESET_VECTOR);

`ifdef PC_FORCE_ALIGN_EN
    localparam logic [WIDTH-1:0] RST_VAL = {RV_SIZED[WIDTH-1:2], 2'b00};
`else
    localparam logic [WIDTH-1:0] RST_VAL = RV_SIZED;
`endif

    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] pc_d;
    logic             started_q;

    always_comb begin
        pc_d = pc_bus.PCin;
`ifdef PC_FORCE_ALIGN_EN
        pc_d = {pc_bus.PCin[WIDTH-1:2], 2'b00};
`endif
    end

    // Reset wins over a coincident clock edge because it is in the sensitivity
    // list and tested first; release is only seen at the next rising edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc_q      <= RST_VAL;
            started_q <= 1'b0;
        end else begin
            pc_q      <= pc_d;
            started_q <= 1'b1;
        end
    end

    assign pc_bus.PCout   = pc_q;
    assign pc_bus.started = started_q;
    // Modular add: carry-out past WIDTH is dropped, so the top address wraps to 0.
    assign pc_bus.PCplus4 = pc_q + WIDTH'(PC_STEP);

`ifdef PC_FORCE_ALIGN_EN
    assign pc_bus.misaligned = 1'b0;
`else
    assign pc_bus.misaligned = |pc_q[1:0];
`endif

endmodule : pc_reg

// File: tb/tb_pc_reg.sv
module tb_pc_reg;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] plus4;
        logic        mis;
        logic        started;
    } exp_t;

    logic clock;
    logic reset;

    pc_reg_if #(.WIDTH(32)) bus ();

    pc_reg #(
        .WIDTH       (32),
        .RESET_VECTOR(32'h0000_0000)
    ) dut (
        .clock (clock),
        .reset (reset),
        .pc_bus(bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int   n_vec  = 0;
    int   n_fail = 0;
    exp_t exp_q[$];
    event obs_ev;

    // Reference model state: the architectural PC and the started flag.
    longint unsigned m_pc;
    bit              m_started;

    function automatic longint unsigned align_in(input longint unsigned v);
`ifdef PC_FORCE_ALIGN_EN
        return (v / 4) * 4;
`else
        return v;
`endif
    endfunction

    function automatic exp_t expect_now();
        exp_t e;
        e.pc      = 32'(m_pc);
        e.plus4   = 32'((m_pc + 4) % 64'h1_0000_0000);
`ifdef PC_FORCE_ALIGN_EN
        e.mis     = 1'b0;
`else
        e.mis     = (m_pc % 4) != 0;
`endif
        e.started = m_started;
        return e;
    endfunction

    function automatic void model_reset();
        m_pc      = align_in(0);
        m_started = 0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: pops one expectation per observation point and compares all outputs.
    initial begin
        exp_t e;
        forever begin
            @(obs_ev);
            if (exp_q.size() == 0) begin
                n_vec++;
                n_fail++;
                $display("FAIL scoreboard: observation with empty queue at %0t", $time);
            end else begin
                e = exp_q.pop_front();
                chk("PCout",      bus.PCout,             e.pc);
                chk("PCplus4",    bus.PCplus4,           e.plus4);
                chk("misaligned", {31'b0, bus.misaligned}, {31'b0, e.mis});
                chk("started",    {31'b0, bus.started},    {31'b0, e.started});
            end
        end
    end

    // One clock cycle: drive at negedge, model the edge, observe #1 after posedge.
    task automatic step(input logic [31:0] pcin, input logic rst);
        @(negedge clock);
        reset    = rst;
        bus.PCin = pcin;
        if (rst) model_reset();
        else begin
            m_pc      = align_in(pcin);
            m_started = 1;
        end
        exp_q.push_back(expect_now());
        @(posedge clock);
        #1;
        -> obs_ev;
    endtask

    // Raise reset between edges and check the asynchronous effect; reset stays high.
    task automatic async_reset();
        @(posedge clock);
        #2;
        reset = 1'b1;
        model_reset();
        exp_q.push_back(expect_now());
        #1;
        -> obs_ev;
    endtask

    // Hard watchdog so the run can never hang.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r;
        reset    = 1'b1;
        bus.PCin = 32'h0;
        model_reset();

        // Reset state while reset is held.
        #100;
        exp_q.push_back(expect_now());
        -> obs_ev;

        // Release, then hold PCin == PCout for three cycles.
        step(32'h0, 1'b0);
        for (int i = 0; i < 3; i++) step(32'(m_pc), 1'b0);

        // Load and step via PCplus4.
        step(32'h20, 1'b0);
        for (int i = 0; i < 2; i++) step(32'((m_pc + 4) % 64'h1_0000_0000), 1'b0);

        // Async reset mid-run, then release with PCin = 0x20.
        async_reset();
        step(32'h20, 1'b0);

        // Reset held across a clock edge keeps the reset state.
        step(32'h1234_5678, 1'b1);
        step(32'h40, 1'b0);

        // Wrap and alignment.
        step(32'hFFFF_FFFC, 1'b0);
        step(32'h0000_0023, 1'b0);
        step(32'hFFFF_FFFF, 1'b0);

        // Randomized load sequence with occasional async reset pulses.
        for (int i = 0; i < 300; i++) begin
            r = $urandom;
            if ($urandom_range(0, 24) == 0) async_reset();
            else if ($urandom_range(0, 3) == 0) step(32'((m_pc + 4) % 64'h1_0000_0000), 1'b0);
            else step(r, ($urandom_range(0, 29) == 0) ? 1'b1 : 1'b0);
        end
        step(32'h100, 1'b0);

        #2;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule : tb_pc_reg
